// File: rtl/present_pkg.sv
// Shared PRESENT-80 tables, bit permutations and key-schedule steps.
// Used by the iterative decryptor and its inverse-round datapath.
package present_pkg;

    localparam int DATA_W = 64;
    localparam int KEY_W  = 80;

    typedef enum logic [1:0] {IDLE, KEYEXP, DEC, DONE} state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    function automatic logic [DATA_W-1:0] p_layer(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) y[(16*i)%63] = x[i];
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [DATA_W-1:0] inv_p_layer(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) y[i] = x[(16*i)%63];
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [DATA_W-1:0] inv_s_layer(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = INV_SBOX[x[4*n +: 4]];
        return y;
    endfunction

    function automatic logic [KEY_W-1:0] key_upd(input logic [KEY_W-1:0] k,
                                                 input logic [4:0] rc);
        logic [KEY_W-1:0] t;
        t = {k[18:0], k[79:19]};
        t[79:76] = SBOX[t[79:76]];
        t[19:15] = t[19:15] ^ rc;
        return t;
    endfunction

    // Exact inverse of key_upd: undo the counter xor, the S-box, then the rotation.
    function automatic logic [KEY_W-1:0] key_iupd(input logic [KEY_W-1:0] k,
                                                  input logic [4:0] rc);
        logic [KEY_W-1:0] t;
        t = k;
        t[19:15] = t[19:15] ^ rc;
        t[79:76] = INV_SBOX[t[79:76]];
        return {t[60:0], t[79:61]};
    endfunction

endpackage

// File: rtl/present_inv_round.sv
// One combinational PRESENT inverse round: invP, then invS, then round-key xor.
module present_inv_round
    import present_pkg::*;
(
    input  logic [63:0] st,
    input  logic [63:0] rk,
    output logic [63:0] res
);

    assign res = inv_s_layer(inv_p_layer(st)) ^ rk;

endmodule

// File: rtl/present_dec_iter.sv
// Iterative PRESENT-80 decryptor: forward key expansion to the last round key, then inverse rounds.
// Optional last-round-key cache enabled by defining PRESENT_DEC_KEYCACHE_EN.
module present_dec_iter
    import present_pkg::*;
#(
    parameter int ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [79:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    localparam logic [4:0] RC_LAST = 5'(ROUNDS);

    state_t      state, state_nx;
    logic [63:0] st, st_dec;
    logic [79:0] key, k_up, k_dn;
    logic [4:0]  rc;
    logic        hit;
    logic [79:0] klast;

    assign k_up = key_upd(key, rc);
    assign k_dn = key_iupd(key, rc);

    present_inv_round u_inv_round (
        .st  (st),
        .rk  (k_dn[79:16]),
        .res (st_dec)
    );

`ifdef PRESENT_DEC_KEYCACHE_EN
    logic [79:0] cache_k, cache_klast;
    logic        cache_v;

    assign hit   = cache_v && (in_key == cache_k);
    assign klast = cache_klast;

    // cache_k is captured at a missing acceptance; cache_v only rises once the
    // matching last round key is known, so the pair is always consistent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cache_k     <= '0;
            cache_klast <= '0;
            cache_v     <= 1'b0;
        end else begin
            if (state == IDLE && in_valid && !hit) begin
                cache_k <= in_key;
                cache_v <= 1'b0;
            end
            if (state == KEYEXP && rc == RC_LAST) begin
                cache_klast <= k_up;
                cache_v     <= 1'b1;
            end
        end
    end
`else
    assign hit   = 1'b0;
    assign klast = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = hit ? DEC : KEYEXP;
            KEYEXP:  if (rc == RC_LAST) state_nx = DEC;
            DEC:     if (rc == 5'd1) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st       <= '0;
            key      <= '0;
            rc       <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (hit) begin
                            st  <= in_data ^ klast[79:16];
                            key <= klast;
                            rc  <= RC_LAST;
                        end else begin
                            st  <= in_data;
                            key <= in_key;
                            rc  <= 5'd1;
                        end
                    end
                end
                KEYEXP: begin
                    key <= k_up;
                    // Whitening with the final round key; rc parks at ROUNDS for the descent.
                    if (rc == RC_LAST) st <= st ^ k_up[79:16];
                    else               rc <= rc + 5'd1;
                end
                DEC: begin
                    st  <= st_dec;
                    key <= k_dn;
                    rc  <= rc - 5'd1;
                    if (rc == 5'd1) out_data <= st_dec;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == KEYEXP) || (state == DEC);

endmodule

// File: tb/tb_present_dec_iter.sv
// Directed bench for present_dec_iter using the published PRESENT-80 vectors.
module tb_present_dec_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [79:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [79:0] K0 = 80'h0;
    localparam logic [79:0] KF = {80{1'b1}};
    localparam logic [63:0] PF = 64'hFFFF_FFFF_FFFF_FFFF;

`ifdef PRESENT_DEC_KEYCACHE_EN
    localparam int LAT_HIT = 31;
`else
    localparam int LAT_HIT = 62;
`endif

    present_dec_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one block for a single cycle, then wait for out_valid (bounded).
    task automatic run_block(input logic [63:0] ct, input logic [79:0] k,
                             output int lat, output bit to);
        in_data  = ct;
        in_key   = k;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        to  = 1'b0;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) to = 1'b1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++;
        if (out_data !== 64'h0) begin n_err++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    endtask

    task automatic test_vectors();
        logic [63:0] ct  [3] = '{64'h5579C1387B228445, 64'hE72C46C0F5945049, 64'hA112FFC72F68417B};
        logic [79:0] ky  [3] = '{K0, KF, K0};
        logic [63:0] pt  [3] = '{64'h0, 64'h0, PF};
        int lat;
        bit to;
        for (int v = 0; v < 3; v++) begin
            run_block(ct[v], ky[v], lat, to);
            n_cmp++;
            if (to) begin n_err++; $display("FAIL vec%0d_timeout out_valid never rose", v); end
            n_cmp++;
            if (out_data !== pt[v]) begin n_err++; $display("FAIL vec%0d_data got=%h exp=%h", v, out_data, pt[v]); end
            n_cmp++;
            if (lat != 62) begin n_err++; $display("FAIL vec%0d_latency got=%0d exp=62", v, lat); end
            handshake();
            n_cmp++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL vec%0d_in_ready_after got=%b exp=1", v, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        run_block(64'h3333DCD3213210D2, KF, lat, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL bp_timeout out_valid never rose"); end
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (out_data !== PF || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cyc=%0d data=%h valid=%b in_ready=%b exp data=%h valid=1 in_ready=0",
                         c, out_data, out_valid, in_ready, PF);
            end
            @(posedge clk); #1;
        end
        handshake();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
        n_cmp++;
        if (out_data !== PF) begin n_err++; $display("FAIL bp_out_hold got=%h exp=%h", out_data, PF); end
    endtask

    task automatic test_ignore_inputs();
        int lat;
        in_data  = 64'hA112FFC72F68417B;
        in_key   = K0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 40; c++) begin
            in_valid = c[0];
            in_data  = {32'hDEAD_0000, 32'(c)};
            in_key   = {16'hBEEF, 32'(c), 32'(c * 7)};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (out_data !== PF || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL ignore_inputs data=%h valid=%b exp data=%h valid=1", out_data, out_valid, PF);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit to;
        in_data  = 64'h3333DCD3213210D2;
        in_key   = KF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (51) begin @(posedge clk); #1; end
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_state in_ready=%b busy=%b out_valid=%b exp 1/0/0", in_ready, busy, out_valid);
        end
        n_cmp++;
        if (out_data !== 64'h0) begin n_err++; $display("FAIL rstmid_out_data got=%h exp=0", out_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(64'hA112FFC72F68417B, K0, lat, to);
        n_cmp++;
        if (to || out_data !== PF) begin
            n_err++;
            $display("FAIL rstmid_fresh timeout=%b data=%h exp=%h", to, out_data, PF);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [63:0] ct  [3] = '{64'h5579C1387B228445, 64'hA112FFC72F68417B, 64'hE72C46C0F5945049};
        logic [79:0] ky  [3] = '{K0, K0, KF};
        logic [63:0] pt  [3] = '{64'h0, PF, 64'h0};
        int          el  [3] = '{62, LAT_HIT, 62};
        int lat;
        bit to;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int v = 0; v < 3; v++) begin
            run_block(ct[v], ky[v], lat, to);
            n_cmp++;
            if (to || out_data !== pt[v]) begin
                n_err++;
                $display("FAIL b2b%0d_data timeout=%b got=%h exp=%h", v, to, out_data, pt[v]);
            end
            n_cmp++;
            if (lat != el[v]) begin n_err++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", v, lat, el[v]); end
            handshake();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_vectors();
        test_backpressure();
        test_ignore_inputs();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
